// File: rtl/vdc_cpu_port.sv
// Purpose  : CPU-side bus port of the VDC: 4-address 8-bit port into a 16-bit register file,
//            VRAM read/write sequencing via req/ack, sticky event flags, BUSY_n and IRQ_n.
// Latency  : register writes land 1 cycle after the strobe; a VRAM access holds req until ack (min 2 cycles strobe->IDLE).
// Backpres.: only one VRAM access outstanding; data-port strobes (A=2/3) arriving while busy are dropped.
// Ports    : clock/reset_n; CPU pins CS_n/RD_n/WR_n/A/DI/DO/BUSY_n/IRQ_n; evt_set event pulses;
//            reg_q flattened register file (reg i at [16i+15:16i]); vram_* request/ack channel to the arbiter.
module vdc_cpu_port #(
    parameter int NUM_REGS = 20,
    parameter int NUM_EVT  = 6,
    parameter int VADDR_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     CS_n,
    input  logic                     RD_n,
    input  logic                     WR_n,
    input  logic [1:0]               A,
    input  logic [7:0]               DI,
    output logic [7:0]               DO,
    output logic                     BUSY_n,
    output logic                     IRQ_n,
    input  logic [NUM_EVT-1:0]       evt_set,
    output logic [16*NUM_REGS-1:0]   reg_q,
    output logic                     vram_req,
    output logic                     vram_we,
    output logic [VADDR_W-1:0]       vram_addr,
    output logic [15:0]              vram_wdata,
    input  logic                     vram_ack,
    input  logic [15:0]              vram_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    // Pointers live in 16-bit registers; only the low VADDR_W bits take part in wrap-around.
    localparam logic [15:0] PTR_MASK = (VADDR_W >= 16) ? 16'hFFFF : 16'((64'd1 << VADDR_W) - 64'd1);

    state_t               state_q, state_d;
    logic                 rd_n_prev_q, rd_n_prev_d;
    logic                 wr_n_prev_q, wr_n_prev_d;
    logic [4:0]           ar_q, ar_d;
    logic [15:0]          regs_q [NUM_REGS];
    logic [15:0]          regs_d [NUM_REGS];
    logic [15:0]          vrr_q, vrr_d;
    logic [NUM_EVT-1:0]   flags_q, flags_d;
    logic [VADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;

    logic                 rd_stb, wr_stb, idle, ar_valid;
    logic                 start_wr, start_rd;
    logic [15:0]          inc;
    logic [15:0]          marr_inc;
    logic [15:0]          rd_word;
    logic [15:0]          regs_ext [32];

    function automatic logic [15:0] ptr_add(input logic [15:0] p, input logic [15:0] step);
        logic [15:0] sum;
        sum = p + step;
        return (p & ~PTR_MASK) | (sum & PTR_MASK);
    endfunction

    // Zero-padded view so fixed indices (CR at 5) and AR-indexed reads are safe for any NUM_REGS.
    for (genvar g = 0; g < 32; g++) begin : g_ext
        if (g < NUM_REGS) begin : g_live
            assign regs_ext[g] = regs_q[g];
        end else begin : g_pad
            assign regs_ext[g] = 16'h0000;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[16*g +: 16] = regs_q[g];
    end

    // One pulse per falling edge; the history flops make a held-low strobe fire only once.
    assign rd_stb   = ~CS_n & ~RD_n & rd_n_prev_q;
    assign wr_stb   = ~CS_n & ~WR_n & wr_n_prev_q;
    assign idle     = (state_q == ST_IDLE);
    assign ar_valid = (32'(ar_q) < NUM_REGS);

    always_comb begin
        inc = 16'd1;
        case (regs_ext[5][12:11])
            2'b00:   inc = 16'd1;
            2'b01:   inc = 16'd32;
            2'b10:   inc = 16'd64;
            default: inc = 16'd128;
        endcase
    end

    assign marr_inc = ptr_add(regs_ext[1], inc);

    // Datapath: register file, pointers, read-back latch, flags and access launch.
    always_comb begin
        rd_n_prev_d = RD_n;
        wr_n_prev_d = WR_n;
        ar_d        = ar_q;
        regs_d      = regs_q;
        vrr_d       = vrr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        start_wr    = 1'b0;
        start_rd    = 1'b0;

        // AR stays writable during an access so the CPU can prepare the next one.
        if (wr_stb && A == 2'd0) begin
            ar_d = DI[4:0];
        end

        if (wr_stb && idle && ar_valid && A == 2'd2) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_q) == i) regs_d[i][7:0] = DI;
            end
        end

        if (wr_stb && idle && ar_valid && A == 2'd3) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_q) == i) regs_d[i][15:8] = DI;
            end
            if (ar_q == 5'd2) begin
                start_wr = 1'b1;
                addr_d   = VADDR_W'(regs_ext[0]);
                wdata_d  = {DI, regs_ext[2][7:0]};
            end else if (ar_q == 5'd1) begin
                start_rd = 1'b1;
                addr_d   = VADDR_W'({DI, regs_ext[1][7:0]});
            end
        end

        // Reading the VRR high byte prefetches the next word.
        if (rd_stb && idle && A == 2'd3 && ar_q == 5'd2) begin
            regs_d[1] = marr_inc;
            start_rd  = 1'b1;
            addr_d    = VADDR_W'(marr_inc);
        end

        if (vram_ack && state_q == ST_WR) begin
            regs_d[0] = ptr_add(regs_ext[0], inc);
        end
        if (vram_ack && state_q == ST_RD) begin
            vrr_d = vram_rdata;
        end

        // A set in the same cycle as the status-read clear wins.
        flags_d = ((rd_stb && A == 2'd0) ? '0 : flags_q) | evt_set;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_wr)      state_d = ST_WR;
                else if (start_rd) state_d = ST_RD;
            end
            ST_WR, ST_RD: begin
                if (vram_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vram_req = (state_q != ST_IDLE);
        vram_we  = (state_q == ST_WR);
        BUSY_n   = (state_q == ST_IDLE);
    end

    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign IRQ_n      = ~|(flags_q & regs_ext[5][NUM_EVT-1:0]);

    // AR=2 reads return the VRAM read latch rather than VWR.
    always_comb begin
        rd_word = 16'h0000;
        if (ar_q == 5'd2)  rd_word = vrr_q;
        else if (ar_valid) rd_word = regs_ext[ar_q];
    end

    always_comb begin
        logic [7:0] status;
        status                = 8'h00;
        status[6]             = ~BUSY_n;
        status[NUM_EVT-1:0]   = flags_q;
        DO = 8'h00;
        if (~CS_n && ~RD_n) begin
            case (A)
                2'd0:    DO = status;
                2'd2:    DO = rd_word[7:0];
                2'd3:    DO = rd_word[15:8];
                default: DO = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_n_prev_q <= 1'b1;
            wr_n_prev_q <= 1'b1;
            ar_q        <= '0;
            vrr_q       <= '0;
            flags_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rd_n_prev_q <= rd_n_prev_d;
            wr_n_prev_q <= wr_n_prev_d;
            ar_q        <= ar_d;
            vrr_q       <= vrr_d;
            flags_q     <= flags_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_vdc_cpu_port.sv
module tb_vdc_cpu_port;

    localparam int NUM_REGS = 20;
    localparam int NUM_EVT  = 6;
    localparam int VADDR_W  = 16;

    logic                   clock;
    logic                   reset_n;
    logic                   CS_n, RD_n, WR_n;
    logic [1:0]             A;
    logic [7:0]             DI;
    logic [7:0]             DO;
    logic                   BUSY_n, IRQ_n;
    logic [NUM_EVT-1:0]     evt_set;
    logic [16*NUM_REGS-1:0] reg_q;
    logic                   vram_req, vram_we;
    logic [VADDR_W-1:0]     vram_addr;
    logic [15:0]            vram_wdata;
    logic                   vram_ack;
    logic [15:0]            vram_rdata;

    int passed = 0;
    int total  = 0;
    int ack_wait = 0;
    logic [15:0] rdata_val = 16'h0000;

    vdc_cpu_port #(.NUM_REGS(NUM_REGS), .NUM_EVT(NUM_EVT), .VADDR_W(VADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
        .A(A), .DI(DI), .DO(DO), .BUSY_n(BUSY_n), .IRQ_n(IRQ_n), .evt_set(evt_set),
        .reg_q(reg_q), .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // VRAM responder: ack after ack_wait request cycles without ack.
    initial begin
        int cnt;
        cnt = 0;
        vram_ack   = 1'b0;
        vram_rdata = 16'h0000;
        forever begin
            @(negedge clock);
            if (vram_req && !vram_ack) begin
                if (cnt == ack_wait) begin
                    vram_ack   = 1'b1;
                    vram_rdata = rdata_val;
                end else begin
                    cnt++;
                end
            end else begin
                vram_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        CS_n = 1'b0; WR_n = 1'b0; A = a; DI = d;
        @(negedge clock);
        WR_n = 1'b1; CS_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clock);
        CS_n = 1'b0; RD_n = 1'b0; A = a;
        #1 d = DO;
        @(negedge clock);
        RD_n = 1'b1; CS_n = 1'b1;
    endtask

    task automatic pulse_evt(input logic [NUM_EVT-1:0] e);
        @(negedge clock);
        evt_set = e;
        @(negedge clock);
        evt_set = '0;
    endtask

    // Counts cycles with BUSY_n low, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY_n !== 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int n;
        CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; A = 2'd0; DI = 8'h00;
        evt_set = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req",   32'(vram_req), 32'd0);
        check("rst_busy",  32'(BUSY_n),   32'd1);
        check("rst_irq",   32'(IRQ_n),    32'd1);
        check("rst_regs",  32'(|reg_q),   32'd0);
        reset_n = 1'b1;

        // 1: pointer setup and a VRAM write
        cpu_wr(2'd0, 8'h00); cpu_wr(2'd2, 8'h00); cpu_wr(2'd3, 8'h10);
        check("mawr_init", 32'(reg_q[15:0]), 32'h1000);
        check("no_req_ar0", 32'(vram_req), 32'd0);
        cpu_wr(2'd0, 8'h05); cpu_wr(2'd3, 8'h08);
        check("cr_inc32", 32'(reg_q[95:80]), 32'h0800);
        ack_wait = 2;
        cpu_wr(2'd0, 8'h02); cpu_wr(2'd2, 8'h34); cpu_wr(2'd3, 8'h12);
        check("wr_req",   32'(vram_req),   32'd1);
        check("wr_we",    32'(vram_we),    32'd1);
        check("wr_addr",  32'(vram_addr),  32'h1000);
        check("wr_wdata", 32'(vram_wdata), 32'h1234);
        check("wr_busy",  32'(BUSY_n),     32'd0);
        cpu_rd(2'd0, d);
        check("status_busy", 32'(d), 32'h40);
        wait_idle(n);
        check("mawr_inc", 32'(reg_q[15:0]), 32'h1020);
        check("vwr",      32'(reg_q[47:32]), 32'h1234);

        // 2: MARR write launches a read; slow ack
        ack_wait = 5; rdata_val = 16'hBEEF;
        cpu_wr(2'd0, 8'h01); cpu_wr(2'd3, 8'h20);
        check("rd_req",  32'(vram_req),  32'd1);
        check("rd_we",   32'(vram_we),   32'd0);
        check("rd_addr", 32'(vram_addr), 32'h2000);
        wait_idle(n);
        check("rd_busy_cycles", 32'(n), 32'd6);
        check("marr", 32'(reg_q[31:16]), 32'h2000);
        cpu_wr(2'd0, 8'h02);
        cpu_rd(2'd2, d);
        check("vrr_lo", 32'(d), 32'hEF);
        ack_wait = 0; rdata_val = 16'h5A5A;
        cpu_rd(2'd3, d);
        check("vrr_hi", 32'(d), 32'hBE);
        check("prefetch_req",  32'(vram_req),  32'd1);
        check("prefetch_addr", 32'(vram_addr), 32'h2020);
        wait_idle(n);
        check("min_latency", 32'(n), 32'd1);
        check("marr_inc", 32'(reg_q[31:16]), 32'h2020);
        cpu_rd(2'd2, d);
        check("vrr_new", 32'(d), 32'h5A);

        // 3: increment 128 and pointer wrap
        cpu_wr(2'd0, 8'h05); cpu_wr(2'd3, 8'h18);
        cpu_wr(2'd0, 8'h00); cpu_wr(2'd2, 8'hC0); cpu_wr(2'd3, 8'hFF);
        ack_wait = 1;
        cpu_wr(2'd0, 8'h02); cpu_wr(2'd2, 8'h78); cpu_wr(2'd3, 8'h56);
        check("wrap_addr",  32'(vram_addr),  32'hFFC0);
        check("wrap_wdata", 32'(vram_wdata), 32'h5678);
        wait_idle(n);
        check("mawr_wrap", 32'(reg_q[15:0]), 32'h0040);

        // 4: data strobes dropped while busy, AR still writable
        ack_wait = 4;
        cpu_wr(2'd3, 8'h9A);
        cpu_wr(2'd3, 8'h11);
        cpu_wr(2'd0, 8'h01);
        check("busy_window", 32'(BUSY_n), 32'd0);
        wait_idle(n);
        @(negedge clock);
        check("no_second_req", 32'(vram_req), 32'd0);
        check("vwr_kept",  32'(reg_q[47:32]), 32'h9A78);
        check("mawr_busy", 32'(reg_q[15:0]),  32'h00C0);
        cpu_rd(2'd2, d);
        check("ar_busy_write", 32'(d), 32'h20);

        // out-of-range AR
        cpu_wr(2'd0, 8'd25); cpu_wr(2'd2, 8'hFF);
        cpu_rd(2'd2, d);
        check("oor_lo", 32'(d), 32'h00);
        cpu_rd(2'd3, d);
        check("oor_hi", 32'(d), 32'h00);

        // 5: flags and IRQ
        cpu_wr(2'd0, 8'h05); cpu_wr(2'd2, 8'h01);
        check("cr_en", 32'(reg_q[95:80]), 32'h1801);
        check("irq_idle", 32'(IRQ_n), 32'd1);
        pulse_evt(6'b000001);
        check("irq_set", 32'(IRQ_n), 32'd0);
        cpu_rd(2'd0, d);
        check("status_flag0", 32'(d), 32'h01);
        check("irq_cleared", 32'(IRQ_n), 32'd1);
        pulse_evt(6'b000010);
        check("irq_masked", 32'(IRQ_n), 32'd1);
        cpu_rd(2'd0, d);
        check("status_flag1", 32'(d), 32'h02);
        @(negedge clock);
        CS_n = 1'b0; RD_n = 1'b0; A = 2'd0; evt_set = 6'b000001;
        @(negedge clock);
        RD_n = 1'b1; CS_n = 1'b1; evt_set = '0;
        check("set_wins_irq", 32'(IRQ_n), 32'd0);
        cpu_rd(2'd0, d);
        check("set_wins_flag", 32'(d), 32'h01);

        // 6: reset mid-access, WR_n held low across release
        pulse_evt(6'b000001);
        check("pre_rst_irq", 32'(IRQ_n), 32'd0);
        ack_wait = 20;
        cpu_wr(2'd0, 8'h02); cpu_wr(2'd3, 8'h9B);
        check("pre_rst_req", 32'(vram_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_req",  32'(vram_req), 32'd0);
        check("rst_mid_busy", 32'(BUSY_n),   32'd1);
        check("rst_mid_irq",  32'(IRQ_n),    32'd1);
        WR_n = 1'b0; CS_n = 1'b1; A = 2'd0; DI = 8'h07;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check("rst_regs2", 32'(|reg_q), 32'd0);
        repeat (2) @(negedge clock);
        CS_n = 1'b0;
        repeat (2) @(negedge clock);
        CS_n = 1'b1; WR_n = 1'b1;
        check("rst_no_req", 32'(vram_req), 32'd0);
        cpu_wr(2'd2, 8'hAB);
        check("held_wr_no_stb", 32'(reg_q[15:0]), 32'h00AB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
